// File: rtl/arbitro_escritura_banco_pkg.sv
// rtl/arbitro_escritura_banco_pkg.sv - shared constants and enums for the register-bank write arbiter
package arbitro_escritura_banco_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 16;

    typedef enum logic {
        INIT,
        RUN
    } estado_t;

    typedef enum logic {
        REQ_ALU,
        REQ_MEM
    } req_t;

endpackage

// File: rtl/arbitro_escritura_banco_rr2.sv
// rtl/arbitro_escritura_banco_rr2.sv - two-way round-robin grant with load-priority override
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   habilitar_i   arbitration enabled (RUN); no grants while low
//   req_alu_i     ALU request valid
//   req_mem_i     load request valid
//   prio_mem_i    same-address conflict: load goes first
//   gnt_alu_o     ALU granted (only ever high together with req_alu_i)
//   gnt_mem_o     load granted (only ever high together with req_mem_i)
module arbitro_rr2
    import arbitro_escritura_banco_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic habilitar_i,
    input  logic req_alu_i,
    input  logic req_mem_i,
    input  logic prio_mem_i,
    output logic gnt_alu_o,
    output logic gnt_mem_o
);

    req_t ultimo_grant_q, ultimo_grant_d;
    // ALU was valid but not granted last cycle; it must win now so the
    // load-priority override cannot starve it with back-to-back loads.
    logic alu_espero_q, alu_espero_d;

    always_comb begin
        gnt_alu_o = 1'b0;
        gnt_mem_o = 1'b0;
        if (habilitar_i) begin
            if (req_alu_i && req_mem_i) begin
                if (alu_espero_q) begin
                    gnt_alu_o = 1'b1;
                end else if (prio_mem_i) begin
                    gnt_mem_o = 1'b1;
                end else if (ultimo_grant_q == REQ_MEM) begin
                    gnt_alu_o = 1'b1;
                end else begin
                    gnt_mem_o = 1'b1;
                end
            end else begin
                gnt_alu_o = req_alu_i;
                gnt_mem_o = req_mem_i;
            end
        end
    end

    always_comb begin
        ultimo_grant_d = ultimo_grant_q;
        if (gnt_alu_o) begin
            ultimo_grant_d = REQ_ALU;
        end else if (gnt_mem_o) begin
            ultimo_grant_d = REQ_MEM;
        end
        alu_espero_d = habilitar_i & req_alu_i & ~gnt_alu_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ultimo_grant_q <= REQ_MEM;
            alu_espero_q   <= 1'b0;
        end else begin
            ultimo_grant_q <= ultimo_grant_d;
            alu_espero_q   <= alu_espero_d;
        end
    end

endmodule

// File: rtl/arbitro_escritura_banco.sv
// rtl/arbitro_escritura_banco.sv - write-port arbiter and sequencer for the 32x32 register bank
//
// Optional feature macro: INIT_CLEAR_EN (post-reset clear of registers 1..NUM_REGS-1).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_dir/alu_dato      ALU write-back request
//   alu_ready                       ALU request accepted this cycle
//   mem_valid/mem_dir/mem_dato      load write-back request
//   mem_ready                       load request accepted this cycle
//   wEnable/dirEsc/datoIn           registered bank write port
//   ocupado                         clear sequence in progress
//   cnt_conflictos                  saturating count of both-valid RUN cycles
module arbitro_escritura_banco #(
    parameter int DATA_W   = arbitro_escritura_banco_pkg::DATA_W,
    parameter int ADDR_W   = arbitro_escritura_banco_pkg::ADDR_W,
    parameter int NUM_REGS = arbitro_escritura_banco_pkg::NUM_REGS,
    parameter int CNT_W    = arbitro_escritura_banco_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dir,
    input  logic [DATA_W-1:0] alu_dato,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dir,
    input  logic [DATA_W-1:0] mem_dato,
    output logic              mem_ready,
    output logic              wEnable,
    output logic [ADDR_W-1:0] dirEsc,
    output logic [DATA_W-1:0] datoIn,
    output logic              ocupado,
    output logic [CNT_W-1:0]  cnt_conflictos
);

    import arbitro_escritura_banco_pkg::*;

    // The clear counter walks addresses 1..NUM_REGS-1 in an ADDR_W-bit register.
    if (NUM_REGS > (1 << ADDR_W)) begin : g_num_regs_invalido
        $error("NUM_REGS exceeds the address space");
    end

    logic              en_run;
    logic              clr_activo;
    logic [ADDR_W-1:0] clr_dir;

`ifdef INIT_CLEAR_EN
    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] clr_q, clr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INIT;
            clr_q    <= ADDR_W'(1);
        end else begin
            estado_q <= estado_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        clr_d    = clr_q;
        case (estado_q)
            INIT: begin
                if (clr_q == ADDR_W'(NUM_REGS - 1)) begin
                    estado_d = RUN;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            RUN:     estado_d = RUN;
            default: estado_d = INIT;
        endcase
    end

    assign clr_activo = (estado_q == INIT);
    assign clr_dir    = clr_q;
    assign en_run     = (estado_q == RUN);
`else
    assign clr_activo = 1'b0;
    assign clr_dir    = '0;
    assign en_run     = 1'b1;
`endif

    assign ocupado = clr_activo;

    logic conflicto;
    logic prio_mem;
    logic gnt_alu, gnt_mem;

    assign conflicto = alu_valid & mem_valid;
    // Same destination: the load is older in program order, so it is written
    // first and the ALU value lands last.
    assign prio_mem  = conflicto & (alu_dir == mem_dir);

    arbitro_rr2 u_rr2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .habilitar_i (en_run),
        .req_alu_i   (alu_valid),
        .req_mem_i   (mem_valid),
        .prio_mem_i  (prio_mem),
        .gnt_alu_o   (gnt_alu),
        .gnt_mem_o   (gnt_mem)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;

    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic [ADDR_W-1:0] acc_dir;
    logic [DATA_W-1:0] acc_dato;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign acc_dir  = gnt_mem ? mem_dir  : alu_dir;
    assign acc_dato = gnt_mem ? mem_dato : alu_dato;

    always_comb begin
        wen_d  = 1'b0;
        dir_d  = dir_q;
        dato_d = dato_q;
        if (clr_activo) begin
            wen_d  = 1'b1;
            dir_d  = clr_dir;
            dato_d = '0;
        end else if ((gnt_alu || gnt_mem) && (acc_dir != '0)) begin
            // Register 0 is hardwired: the request is consumed but never written.
            wen_d  = 1'b1;
            dir_d  = acc_dir;
            dato_d = acc_dato;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_run && conflicto && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            dir_q  <= '0;
            dato_q <= '0;
            cnt_q  <= '0;
        end else begin
            wen_q  <= wen_d;
            dir_q  <= dir_d;
            dato_q <= dato_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wEnable        = wen_q;
    assign dirEsc         = dir_q;
    assign datoIn         = dato_q;
    assign cnt_conflictos = cnt_q;

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// tb/tb_arbitro_escritura_banco.sv - scoreboard bench for the register-bank write arbiter
module tb_arbitro_escritura_banco;

    localparam int NUM_REGS = 32;
`ifdef INIT_CLEAR_EN
    localparam bit CON_CLEAR = 1'b1;
`else
    localparam bit CON_CLEAR = 1'b0;
`endif
    localparam int INIT_CICLOS = CON_CLEAR ? NUM_REGS - 1 : 0;

    logic        clk;
    logic        rst_n;
    logic        a_v, m_v;
    logic [4:0]  a_d, m_d;
    logic [31:0] a_dat, m_dat;
    logic        alu_ready, mem_ready;
    logic        wEnable;
    logic [4:0]  dirEsc;
    logic [31:0] datoIn;
    logic        ocupado;
    logic [15:0] cnt_conflictos;

    arbitro_escritura_banco dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (a_v),
        .alu_dir        (a_d),
        .alu_dato       (a_dat),
        .alu_ready      (alu_ready),
        .mem_valid      (m_v),
        .mem_dir        (m_d),
        .mem_dato       (m_dat),
        .mem_ready      (mem_ready),
        .wEnable        (wEnable),
        .dirEsc         (dirEsc),
        .datoIn         (datoIn),
        .ocupado        (ocupado),
        .cnt_conflictos (cnt_conflictos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input bit ok, input string nombre,
                                input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, act, exp);
    endfunction

    // Expected bank writes, tagged with the cycle they must appear in.
    typedef struct {
        int          due;
        logic [4:0]  dir;
        logic [31:0] dato;
    } esc_t;
    esc_t sb[$];

    logic [31:0] dut_bank [NUM_REGS];

    // Reference model state, expressed as the arbitration rules.
    bit          m_ultimo_mem;
    bit          m_alu_esperando;
    int          m_cnt;
    int          m_init_rest;
    bit          a_pend, m_pend;

    task automatic modelo_reset();
        m_ultimo_mem    = 1'b1;
        m_alu_esperando = 1'b0;
        m_cnt           = 0;
        m_init_rest     = INIT_CICLOS;
        a_pend          = 1'b0;
        m_pend          = 1'b0;
        sb.delete();
    endtask

    task automatic esperar(input logic [4:0] dir, input logic [31:0] dato);
        esc_t e;
        e.due  = cyc + 1;
        e.dir  = dir;
        e.dato = dato;
        sb.push_back(e);
    endtask

    task automatic modelo();
        bit ga, gm, ocup;
        ga   = 1'b0;
        gm   = 1'b0;
        ocup = (m_init_rest > 0);
        chk(ocupado == ocup, "ocupado", ocupado, ocup);
        chk(cnt_conflictos == 16'(m_cnt), "cnt_conflictos", cnt_conflictos, m_cnt);
        if (ocup) begin
            esperar(5'(NUM_REGS - m_init_rest), 32'h0);
            m_init_rest--;
        end else begin
            if (a_v && m_v) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_alu_esperando)  ga = 1'b1;
                else if (a_d == m_d)  gm = 1'b1;
                else if (m_ultimo_mem) ga = 1'b1;
                else                   gm = 1'b1;
            end else begin
                ga = a_v;
                gm = m_v;
            end
            if (ga) begin
                m_ultimo_mem = 1'b0;
                if (a_d != 5'd0) esperar(a_d, a_dat);
            end
            if (gm) begin
                m_ultimo_mem = 1'b1;
                if (m_d != 5'd0) esperar(m_d, m_dat);
            end
            m_alu_esperando = a_v && !ga;
        end
        chk(alu_ready == ga, "alu_ready", alu_ready, ga);
        chk(mem_ready == gm, "mem_ready", mem_ready, gm);
        a_pend = a_v && !ga;
        m_pend = m_v && !gm;
    endtask

    // Called at posedge+1; model at +4, monitor at negedge (+5).
    task automatic paso();
        #3;
        modelo();
        @(posedge clk);
        #1;
    endtask

    task automatic fija_alu(input bit v, input logic [4:0] d, input logic [31:0] dat);
        if (!a_pend) begin
            a_v = v; a_d = d; a_dat = dat;
        end
    endtask

    task automatic fija_mem(input bit v, input logic [4:0] d, input logic [31:0] dat);
        if (!m_pend) begin
            m_v = v; m_d = d; m_dat = dat;
        end
    endtask

    task automatic reposo();
        fija_alu(1'b0, 5'd0, 32'h0);
        fija_mem(1'b0, 5'd0, 32'h0);
    endtask

    task automatic reinicio();
        reposo(); paso();
        reposo(); paso();
        reposo();
        rst_n = 1'b0;
        modelo_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (INIT_CICLOS) paso();
    endtask

    // Monitor: every bank write must match the head of the scoreboard in the cycle it is due.
    initial forever begin
        esc_t e;
        @(negedge clk);
        if (rst_n) begin
            if (wEnable) begin
                chk(sb.size() > 0, "write_unexpected", {dirEsc, datoIn}, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk(e.due == cyc, "write_cycle", cyc, e.due);
                    chk(dirEsc == e.dir, "dirEsc", dirEsc, e.dir);
                    chk(datoIn == e.dato, "datoIn", datoIn, e.dato);
                    dut_bank[dirEsc] = datoIn;
                end
            end else if (sb.size() > 0) begin
                chk(sb[0].due > cyc, "write_missing", 0, sb[0].dir);
                if (sb[0].due <= cyc) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_v = 1'b0; a_d = '0; a_dat = '0;
        m_v = 1'b0; m_d = '0; m_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) dut_bank[i] = 32'h0;
        modelo_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(wEnable == 1'b0, "reset_wEnable", wEnable, 0);
        chk(dirEsc == 5'd0, "reset_dirEsc", dirEsc, 0);
        chk(datoIn == 32'h0, "reset_datoIn", datoIn, 0);
        chk(cnt_conflictos == 16'h0, "reset_cnt", cnt_conflictos, 0);
        chk(ocupado == CON_CLEAR, "reset_ocupado", ocupado, CON_CLEAR);

        // Requests already valid at reset release.
        fija_alu(1'b1, 5'd4, 32'hA4A4_0004);
        fija_mem(1'b1, 5'd6, 32'hB6B6_0006);

`ifdef INIT_CLEAR_EN
        rst_n = 1'b1;
        repeat (12) begin reposo(); paso(); end
        chk(dirEsc == 5'd12, "init_dir12", dirEsc, 12);
        chk(ocupado == 1'b1, "init_ocupado", ocupado, 1);
        rst_n = 1'b0;
        modelo_reset();
        #1;
        chk(wEnable == 1'b0, "midinit_wEnable", wEnable, 0);
        chk(dirEsc == 5'd0, "midinit_dirEsc", dirEsc, 0);
        chk(datoIn == 32'h0, "midinit_datoIn", datoIn, 0);
        chk(ocupado == 1'b1, "midinit_ocupado", ocupado, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reposo(); paso();
        chk(dirEsc == 5'd1, "restart_dir1", dirEsc, 1);
        repeat (INIT_CICLOS + 2) begin reposo(); paso(); end
`else
        rst_n = 1'b1;
        repeat (3) begin reposo(); paso(); end
`endif

        reinicio();

        // Distinct addresses, both valid after reset: ALU first, then MEM.
        fija_alu(1'b1, 5'd3, 32'h0000_0333);
        fija_mem(1'b1, 5'd7, 32'h0000_0777);
        paso();
        chk(wEnable && dirEsc == 5'd3, "rr_first_alu", dirEsc, 3);
        reposo(); paso();
        chk(wEnable && dirEsc == 5'd7, "rr_second_mem", dirEsc, 7);
        chk(cnt_conflictos == 16'd1, "rr_cnt", cnt_conflictos, 1);

        // Same address: load written first, ALU value lands last.
        reposo();
        fija_alu(1'b1, 5'd9, 32'h1);
        fija_mem(1'b1, 5'd9, 32'h2);
        paso();
        chk(datoIn == 32'h2, "same_dir_mem_first", datoIn, 2);
        reposo(); paso();
        chk(datoIn == 32'h1, "same_dir_alu_last", datoIn, 1);
        reposo(); paso();
        chk(dut_bank[9] == 32'h1, "bank9_final", dut_bank[9], 1);

        // Single ALU request: one write cycle only.
        fija_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        paso();
        chk(wEnable && dirEsc == 5'd5 && datoIn == 32'hDEAD_BEEF, "single_alu", datoIn, 32'hDEAD_BEEF);
        reposo(); paso();
        chk(wEnable == 1'b0, "single_alu_one_cycle", wEnable, 0);

        // Register 0: consumed, never written.
        fija_alu(1'b1, 5'd0, 32'hFFFF);
        paso();
        chk(wEnable == 1'b0, "reg0_no_write", wEnable, 0);
        reposo(); paso();

        // Randomized traffic with frequent address collisions and register-0 targets.
        repeat (600) begin
            fija_alu($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            fija_mem($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            paso();
        end

        repeat (3) begin reposo(); paso(); end
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_banco.md
Name: arbitro_escritura_banco

Overview:
Write-port arbiter and sequencer for the 32x32 register bank (`bancoRegistros`).
- Accepts write-back requests from two requesters: ALU result path and memory-load path.
- Each requester uses a valid/ready handshake.
- Grants one request per cycle, round-robin.
- Drives the bank's single write port (wEnable, dirEsc, datoIn) from registers.
- Optionally runs a post-reset clear sequence over the whole bank.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, registers covered by the clear sequence.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU write request.
- alu_dir  in  ADDR_W  ALU destination register.
- alu_dato  in  DATA_W  ALU write data.
- alu_ready  out  1  ALU request accepted this cycle (combinational grant).
- mem_valid  in  1  load write request.
- mem_dir  in  ADDR_W  load destination register.
- mem_dato  in  DATA_W  load write data.
- mem_ready  out  1  load request accepted this cycle (combinational grant).
- wEnable  out  1  bank write enable (registered).
- dirEsc  out  ADDR_W  bank write address (registered).
- datoIn  out  DATA_W  bank write data (registered).
- ocupado  out  1  high while the clear sequence runs.
- cnt_conflictos  out  CNT_W  saturating count of cycles where both requests were valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - wEnable=0, dirEsc=0, datoIn=0, cnt_conflictos=0.
  - ultimo_grant=MEM, so ALU wins the first conflict.
  - ocupado: 1 with the feature enabled, 0 without.
- States:
  - INIT: clear sequence, feature only.
  - RUN: normal arbitration.
  - Without the feature, reset goes straight to RUN.
- RUN grant rules:
  - Only one valid request: grant it.
  - Both valid: grant the requester not equal to ultimo_grant. ultimo_grant updates on every grant.
  - A ready output is asserted only when its own valid is high. Accept = valid & ready.
  - The losing requester holds valid/dir/dato stable. It is granted the next cycle at the latest, so the worst-case wait is 1 cycle.
- Same-address conflict (both valid, alu_dir==mem_dir):
  - Overrides round-robin: grant MEM first, ALU next cycle.
  - The ALU value is written last and wins. This matches program order, since the load is older in the pipeline.
  - ultimo_grant is set to MEM.
- Latency: a request accepted in cycle N appears on wEnable/dirEsc/datoIn in cycle N+1 for exactly one cycle. With no accept in cycle N, wEnable=0 in N+1; dirEsc/datoIn hold their last value.
- Register 0:
  - An accepted request with dir==0 is consumed (ready=1).
  - It produces wEnable=0 in N+1; dirEsc/datoIn are unchanged.
- cnt_conflictos increments on every RUN cycle with alu_valid & mem_valid, including same-address cases. It saturates at all-ones with no wrap.
- Outside RUN, both ready outputs are 0 and requests are ignored. Accepted requests are never lost.
- An asynchronous reset at any point, including mid-INIT, returns to the reset values and restarts from the first state.

Optional Feature:
- Macro: INIT_CLEAR_EN.
- When defined:
  - After rst_n deasserts, the block stays in INIT with ocupado=1.
  - An internal counter issues wEnable=1, datoIn=0, dirEsc=1,2,…,NUM_REGS-1, one address per cycle (NUM_REGS-1 cycles).
  - The first clear write appears in the first clk edge after reset release.
  - After the last address, the block enters RUN and ocupado falls in the same cycle; requests are accepted from that cycle.
- When undefined: no INIT state, ocupado tied 0, RUN immediately after reset.

Decomposition:
- Shared package:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - State enum {INIT, RUN}.
  - Requester id enum {REQ_ALU, REQ_MEM}.
- One natural sub-module, arbitro_rr2: a 2-way round-robin grant with priority override input and ultimo_grant register. The rest (FSM, output registers, counter) stays in the top.

Test Plan:
- Single ALU request, alu_dir=5, alu_dato=0xDEADBEEF, cycle N → alu_ready=1 in N; wEnable=1, dirEsc=5, datoIn=0xDEADBEEF in N+1 only.
- Both valid, alu_dir=3 / mem_dir=7, held 2 cycles after reset → ALU granted first, MEM second; writes to 3 then 7 in consecutive cycles; cnt_conflictos=1.
- Both valid, same dir=9, alu_dato=0x1 / mem_dato=0x2 → MEM write (0x2) then ALU write (0x1) to register 9; bank ends with 0x1.
- alu_dir=0, alu_dato=0xFFFF → alu_ready=1; wEnable stays 0 the next cycle.
- INIT_CLEAR_EN defined, reset release with requests already valid → 31 writes of 0 to dirEsc 1..31 with ready=0 and ocupado=1; then requests accepted.
- Reset asserted mid-INIT at dirEsc=12 → outputs clear immediately; after release the sequence restarts at dirEsc=1.
